// File: rtl/seg_msg_scroller_if.sv
// Sequencer-side bus of the message scroller: buffer writes, start/stop control, status and digit codes.
// SEG_SCROLL_HOLD_EN adds the hold signal.
interface seg_msg_scroller_if;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [5:0]  wr_data;
  logic [4:0]  msg_len;
  logic        loop;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic [35:0] digits_out;
`ifdef SEG_SCROLL_HOLD_EN
  logic        hold;
`endif

  modport master (
`ifdef SEG_SCROLL_HOLD_EN
    output hold,
`endif
    output wr_en, wr_addr, wr_data, msg_len, loop, start, stop,
    input  busy, done, digits_out
  );

  modport slave (
`ifdef SEG_SCROLL_HOLD_EN
    input  hold,
`endif
    input  wr_en, wr_addr, wr_data, msg_len, loop, start, stop,
    output busy, done, digits_out
  );
endinterface

// File: rtl/seg_msg_scroller.sv
// Scrolls a message of up to 16 character codes right-to-left across six seven-segment digits.
// Optional SEG_SCROLL_HOLD_EN: the hold input freezes scrolling; stop and reset are still honoured.
module seg_msg_scroller #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  seg_msg_scroller_if.slave ctrl
);
  localparam int unsigned   TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [5:0]    BLANK     = 6'd28;
  localparam logic [35:0]   ALL_BLANK = {6{BLANK}};

  typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [3:0]     ptr_q, ptr_d;
  logic [4:0]     len_q, len_d;
  logic           loop_q, loop_d;
  logic [2:0]     drain_q, drain_d;
  logic [35:0]    digits_q, digits_d;
  logic           done_q, done_d;
  logic [5:0]     buf_q [16];

  logic           hold_w;
  logic           start_ok;
  logic           tick_wrap;
  logic           step_w;
  logic           last_w;
  logic [5:0]     new_char;

`ifdef SEG_SCROLL_HOLD_EN
  assign hold_w = ctrl.hold;
`else
  assign hold_w = 1'b0;
`endif

  assign start_ok  = ctrl.start && (ctrl.msg_len != 5'd0);
  assign tick_wrap = (tick_q == TICK_LAST);
  // stop takes priority over a step landing on the same edge
  assign step_w    = (state_q != IDLE) && !ctrl.stop && !hold_w && tick_wrap;
  assign last_w    = ({1'b0, ptr_q} == (len_q - 5'd1));
  assign new_char  = (state_q == RUN) ? buf_q[ptr_q] : BLANK;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      drain_q  <= '0;
      digits_q <= ALL_BLANK;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      drain_q  <= drain_d;
      digits_q <= digits_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 16; i++) buf_q[i] <= BLANK;
    end else if (state_q == IDLE && ctrl.wr_en) begin
      buf_q[ctrl.wr_addr] <= ctrl.wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (start_ok) state_d = RUN;
    end else if (ctrl.stop) begin
      state_d = IDLE;
    end else if (step_w) begin
      unique case (state_q)
        RUN:     if (last_w) state_d = loop_q ? GAP : DRAIN;
        GAP:     state_d = RUN;
        DRAIN:   if (drain_q == 3'd5) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    tick_d   = tick_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    loop_d   = loop_q;
    drain_d  = drain_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (start_ok) begin
        len_d  = (ctrl.msg_len > 5'd16) ? 5'd16 : ctrl.msg_len;
        loop_d = ctrl.loop;
        ptr_d  = '0;
        tick_d = '0;
      end
    end else if (ctrl.stop) begin
      tick_d   = '0;
      ptr_d    = '0;
      digits_d = ALL_BLANK;
    end else if (!hold_w) begin
      if (tick_wrap) begin
        tick_d   = '0;
        digits_d = {digits_q[29:0], new_char};
        unique case (state_q)
          RUN: begin
            if (last_w) drain_d = '0;
            else        ptr_d   = ptr_q + 4'd1;
          end
          GAP:   ptr_d = '0;
          DRAIN: begin
            drain_d = drain_q + 3'd1;
            if (drain_q == 3'd5) done_d = 1'b1;
          end
          default: ;
        endcase
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  assign ctrl.busy       = (state_q != IDLE);
  assign ctrl.done       = done_q;
  assign ctrl.digits_out = digits_q;
endmodule
